// File: rtl/morph_pkg.sv
// morph_pkg: decision-mode encodings and helpers shared by the mask morphology filter.
package morph_pkg;
  typedef enum logic [1:0] {
    MODE_MEDIAN = 2'd0,
    MODE_DILATE = 2'd1,
    MODE_ERODE  = 2'd2,
    MODE_THRESH = 2'd3
  } mode_e;
  localparam int PIX_W = 24;
  function automatic logic [3:0] popcount(input logic [7:0] v);
    popcount = '0;
    for (int i = 0; i < 8; i++) popcount += {3'b0, v[i]};
  endfunction
endpackage

// File: rtl/morph_line_buf.sv
// morph_line_buf: circular delay line; reads the slot about to be overwritten, so delay equals DEPTH.
module morph_line_buf #(
  parameter int W     = 16,
  parameter int DEPTH = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] wr_i,
  output logic [W-1:0] rd_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] ptr_q;
  assign rd_o = mem_q[ptr_q];
  always_ff @(posedge clk) mem_q[ptr_q] <= wr_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
endmodule

// File: rtl/mask_morph_kxk.sv
// mask_morph_kxk: KxK binary morphology (median/dilate/erode/threshold) on a 1-bit mask stream
// with co-travelling de/h_sync/v_sync; mode and threshold are latched on each v_sync rise.
module mask_morph_kxk
  import morph_pkg::*;
#(
  parameter int K           = 5,
  parameter int H_SIZE      = 1650,
  parameter int BORDER_PASS = 0,
  parameter int CW          = $clog2(K*K+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mask_in,
  input  logic             de_in,
  input  logic             h_sync_in,
  input  logic             v_sync_in,
  input  logic [1:0]       mode,
  input  logic [CW-1:0]    thr,
  output logic             de_out,
  output logic             h_sync_out,
  output logic             v_sync_out,
  output logic             mask_out,
  output logic [PIX_W-1:0] pixel_out,
  output logic [CW-1:0]    count_out
);
  localparam int C    = (K-1)/2;
  localparam int FILL = (K-1)*H_SIZE + K;
  localparam int FW   = $clog2(FILL+1);
  localparam int RW   = $clog2(K+1);
  // taps are {mask, de, hs, vs}; column 0 is the newest sample of each row
  logic [K-1:0][K-1:0][3:0] win_q, win_d;
  logic [K-2:0][3:0]        lb_wr, lb_rd;
  logic [K-1:0][RW-1:0]     rc_q, rc_d;
  logic [CW-1:0]            sum_q, sum_d, thr_q;
  logic [FW-1:0]            fill_q;
  logic [3:0]               c1_q, c2_q;
  logic                     v1_q, v2_q, vs_q, ctx_ok, hit, res;
  logic [7:0]               row;
  mode_e                    mode_q;
  morph_line_buf #(.W(4*(K-1)), .DEPTH(H_SIZE-K)) u_lb (
    .clk  (clk),
    .rst_n(rst_n),
    .wr_i (lb_wr),
    .rd_o (lb_rd)
  );
  always_comb begin
    win_d[0] = {win_q[0][K-2:0], mask_in, de_in, h_sync_in, v_sync_in};
    for (int r = 1; r < K; r++) win_d[r] = {win_q[r][K-2:0], lb_rd[r-1]};
    for (int r = 0; r < K-1; r++) lb_wr[r] = win_q[r][K-1];
    ctx_ok = fill_q == FW'(FILL);
    for (int r = 0; r < K; r++) begin
      row = '0;
      for (int j = 0; j < K; j++) begin
        row[j] = win_q[r][j][3];
        ctx_ok &= win_q[r][j][2];
      end
      rc_d[r] = RW'(popcount(row));
    end
    sum_d = '0;
    for (int r = 0; r < K; r++) sum_d += CW'(rc_q[r]);
    hit = (mode_q == MODE_MEDIAN) ? sum_q > CW'(K*K/2) :
          (mode_q == MODE_DILATE) ? sum_q != '0 :
          (mode_q == MODE_ERODE)  ? sum_q == CW'(K*K) :
                                    sum_q >= thr_q;
    res = v2_q ? hit : (BORDER_PASS != 0) && c2_q[3] && c2_q[2];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win_q      <= '0;
      rc_q       <= '0;
      sum_q      <= '0;
      fill_q     <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      vs_q       <= 1'b0;
      mode_q     <= MODE_MEDIAN;
      thr_q      <= CW'(K*K/2 + 1);
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      mask_out   <= 1'b0;
      count_out  <= '0;
    end else begin
      win_q  <= win_d;
      rc_q   <= rc_d;
      sum_q  <= sum_d;
      fill_q <= (fill_q == FW'(FILL)) ? fill_q : fill_q + FW'(1);
      c1_q   <= win_q[C][C];
      c2_q   <= c1_q;
      v1_q   <= ctx_ok;
      v2_q   <= v1_q;
      vs_q   <= v_sync_in;
      if (v_sync_in && !vs_q) begin
        mode_q <= mode_e'(mode);
        thr_q  <= thr;
      end
      {de_out, h_sync_out, v_sync_out} <= c2_q[2:0];
      mask_out  <= res;
      count_out <= sum_q;
    end
  assign pixel_out = {PIX_W{mask_out}};
endmodule

// File: tb/tb_mask_morph_kxk.sv
// tb_mask_morph_kxk: K=3/H_SIZE=16 bench; two instances (no border pass / border pass) checked
// every cycle against a window model built from the full input history since reset.
module tb_mask_morph_kxk;
  localparam int K = 3, H = 16, CW = 4, LAT = 20;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mask_in = 1'b0, de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [CW-1:0] thr = '0;
  logic de_o, hs_o, vs_o, m_o, de_b, hs_b, vs_b, m_b;
  logic [23:0] px_o, px_b;
  logic [CW-1:0] c_o, c_b;
  mask_morph_kxk #(.K(K), .H_SIZE(H), .BORDER_PASS(0)) dut (
    .clk(clk), .rst_n(rst_n), .mask_in(mask_in), .de_in(de_in), .h_sync_in(hs_in),
    .v_sync_in(vs_in), .mode(mode), .thr(thr), .de_out(de_o), .h_sync_out(hs_o),
    .v_sync_out(vs_o), .mask_out(m_o), .pixel_out(px_o), .count_out(c_o));
  mask_morph_kxk #(.K(K), .H_SIZE(H), .BORDER_PASS(1)) dut_bp (
    .clk(clk), .rst_n(rst_n), .mask_in(mask_in), .de_in(de_in), .h_sync_in(hs_in),
    .v_sync_in(vs_in), .mode(mode), .thr(thr), .de_out(de_b), .h_sync_out(hs_b),
    .v_sync_out(vs_b), .mask_out(m_b), .pixel_out(px_b), .count_out(c_b));
  always #5 clk = ~clk;
  typedef struct { logic mk, de, hs, vs; logic [1:0] md; logic [3:0] th; } smp_t;
  typedef struct { logic [1:0] md; logic [3:0] th; logic [8:0] pat; bit rise; int em, ec; } vec_t;
  smp_t hist[$];
  logic [1:0] sh_md[$];
  logic [3:0] sh_th[$];
  logic o_m[$], o_b[$], o_hs[$], o_de[$], o_vs[$];
  logic [3:0] o_c[$];
  int pass_n = 0, tot_n = 0;
  task automatic chk(input string nm, input int act, input int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
  endtask
  task automatic reset_check();
    chk("rst mask_out", m_o, 0);    chk("rst count_out", c_o, 0);
    chk("rst de_out", de_o, 0);     chk("rst h_sync_out", hs_o, 0);
    chk("rst v_sync_out", vs_o, 0); chk("rst pixel_out", px_o, 0);
    chk("rst bp mask_out", m_b, 0);
  endtask
  // expected outputs after edge n: window is the 3x3 neighbourhood (in raster order) of sample n-LAT
  task automatic model_check();
    int n, m, s;
    bit fill, dv;
    logic e, ex;
    n = hist.size() - 1; m = n - LAT; s = 0; fill = 1; dv = 1;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        int i;
        i = m + dr*H + dc;
        if (i < 0) fill = 0;
        else begin s += int'(hist[i].mk); dv &= hist[i].de; end
      end
    case (sh_md[n])
      2'd0:    e = s > K*K/2;
      2'd1:    e = s > 0;
      2'd2:    e = s == K*K;
      default: e = s >= int'(sh_th[n]);
    endcase
    ex = (fill && dv) ? e : 1'b0;
    chk("mask_out", m_o, ex);
    chk("pixel_out", px_o, ex ? 24'hffffff : 0);
    if (fill) begin chk("count_out", c_o, s); chk("bp count_out", c_b, s); end
    if (m >= 0) begin
      chk("de_out", de_o, hist[m].de); chk("h_sync_out", hs_o, hist[m].hs);
      chk("v_sync_out", vs_o, hist[m].vs); chk("bp de_out", de_b, hist[m].de);
      chk("bp h_sync_out", hs_b, hist[m].hs); chk("bp v_sync_out", vs_b, hist[m].vs);
      chk("bp mask_out", m_b, (fill && dv) ? e : (hist[m].mk & hist[m].de));
    end
  endtask
  task automatic tick(input logic mk, input logic d, input logic h, input logic v);
    mask_in = mk; de_in = d; hs_in = h; vs_in = v;
    if (rst_n) begin
      int n;
      n = hist.size();
      if (n == 0) begin sh_md.push_back(2'd0); sh_th.push_back(4'(K*K/2 + 1)); end
      else if (hist[n-1].vs && (n < 2 || !hist[n-2].vs)) begin
        sh_md.push_back(hist[n-1].md); sh_th.push_back(hist[n-1].th);
      end else begin sh_md.push_back(sh_md[n-1]); sh_th.push_back(sh_th[n-1]); end
      hist.push_back('{mk, d, h, v, mode, thr});
    end
    @(posedge clk);
    @(negedge clk);
    if (rst_n) begin
      model_check();
      o_m.push_back(m_o); o_b.push_back(m_b); o_c.push_back(c_o);
      o_hs.push_back(hs_o); o_de.push_back(de_o); o_vs.push_back(vs_o);
    end else reset_check();
  endtask
  task automatic do_reset(input int cyc);
    rst_n = 1'b0;
    #1 reset_check();
    for (int i = 0; i < cyc; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    hist.delete(); sh_md.delete(); sh_th.delete();
    o_m.delete(); o_b.delete(); o_c.delete(); o_hs.delete(); o_de.delete(); o_vs.delete();
    rst_n = 1'b1;
  endtask
  // zero gap, optional v_sync rise, then a 3x3 pattern around sample c0 on an all-de background
  task automatic run_window(input logic [1:0] md, input logic [3:0] th, input logic [8:0] pat,
                            input bit rise, output int c0);
    mode = md; thr = th;
    for (int i = 0; i < 3*H; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    if (rise) tick(1'b0, 1'b1, 1'b0, 1'b1);
    c0 = hist.size() + H + 2;
    while (hist.size() <= c0 + 2*H + 2 + LAT) begin
      int a;
      logic mk;
      a = hist.size(); mk = 1'b0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++)
          if (a == c0 + dr*H + dc) mk = pat[(dr+1)*3 + dc + 1];
      tick(mk, 1'b1, 1'b0, 1'b0);
    end
  endtask
  initial begin
    vec_t vt[$];
    int c0, first, t, q;
    vt = '{
      '{2'd0, 4'd0, 9'b000010000, 1'b1, 0, 1}, '{2'd1, 4'd0, 9'b000010000, 1'b1, 1, 1},
      '{2'd2, 4'd0, 9'b000010000, 1'b1, 0, 1}, '{2'd0, 4'd0, 9'b101010101, 1'b1, 1, 5},
      '{2'd0, 4'd0, 9'b000011011, 1'b1, 0, 4}, '{2'd2, 4'd0, 9'b111111111, 1'b1, 1, 9},
      '{2'd2, 4'd0, 9'b111101111, 1'b1, 0, 8}, '{2'd1, 4'd0, 9'b000000000, 1'b1, 0, 0},
      '{2'd3, 4'd4, 9'b000011011, 1'b1, 1, 4}, '{2'd3, 4'd5, 9'b000011011, 1'b0, 1, 4},
      '{2'd3, 4'd5, 9'b000011011, 1'b1, 0, 4}, '{2'd3, 4'd0, 9'b000000000, 1'b1, 1, 0},
      '{2'd3, 4'd10, 9'b111111111, 1'b1, 0, 9}, '{2'd3, 4'd9, 9'b111111111, 1'b1, 1, 9}
    };
    @(negedge clk);
    do_reset(3);
    for (int i = 0; i < 50; i++) tick(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    // reset mid-stream, then fill with all ones: first 1 once the window is entirely post-reset
    do_reset(4);
    for (int i = 0; i < 60; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    first = -1;
    for (int i = 0; i < o_m.size(); i++) if (o_m[i] === 1'b1 && first < 0) first = i;
    chk("fill first one", first, (K-1)*H + (K-1) + 3);
    foreach (vt[i]) begin
      run_window(vt[i].md, vt[i].th, vt[i].pat, vt[i].rise, c0);
      chk($sformatf("vec%0d mask", i), o_m[c0 + LAT], vt[i].em);
      chk($sformatf("vec%0d count", i), o_c[c0 + LAT], vt[i].ec);
    end
    run_window(2'd1, 4'd0, 9'b000010000, 1'b1, c0);
    for (int dr = -2; dr <= 2; dr++)
      for (int dc = -2; dc <= 2; dc++)
        chk($sformatf("dilate blk %0d,%0d", dr, dc), o_m[c0 + dr*H + dc + LAT],
            (dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1) ? 1 : 0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    t = hist.size();
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat hs early", o_hs[t + LAT - 1], 0); chk("lat hs", o_hs[t + LAT], 1);
    chk("lat hs late", o_hs[t + LAT + 1], 0);  chk("lat de", o_de[t + LAT], 1);
    chk("lat vs", o_vs[t + LAT], 1);
    // left border: de low in column 0 of every line
    mode = 2'd1;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    q = hist.size() + 3*H + 1;
    for (int i = 0; i < 7*H; i++)
      tick(1'($urandom_range(0, 1)), (hist.size() % H) != ((q - 1) % H), 1'b0, 1'b0);
    for (int i = 0; i < LAT + 2; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("border col", o_m[q + LAT], 0);
    chk("border pass col", o_b[q + LAT], hist[q].mk);
    // random frames with blanking, hs at line end and a fresh mode/thr each v_sync
    for (int f = 0; f < 4; f++) begin
      mode = 2'($urandom_range(0, 3)); thr = 4'($urandom_range(0, 10));
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      for (int l = 0; l < 8; l++) begin
        for (int x = 0; x < H; x++) begin
          if (x == 7 && $urandom_range(0, 3) == 0) begin
            mode = 2'($urandom_range(0, 3)); thr = 4'($urandom_range(0, 10));
          end
          tick(1'($urandom_range(0, 2) != 0), x >= 2 && x < 14, x == 14, 1'b0);
        end
      end
    end
    for (int i = 0; i < LAT + 2*H; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
